// File: rtl/div_iter.sv
// rtl/div_iter.sv - RV32 iterative divider (DIV/DIVU/REM/REMU), restoring shift-subtract
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration.
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  rd,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        wr_ena,
    output logic [4:0]  wr_reg,
    output logic [31:0] wr_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [5:0]  cnt_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        rem_op_q;
    logic [4:0]  rd_q;
    logic        wr_ena_q;
    logic [4:0]  wr_reg_q;
    logic [31:0] wr_data_q;

    // Operand decode at launch
    logic        in_signed;
    logic        in_rem;
    logic        div_zero;
    logic        sgn_ovf;
    logic        special;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [31:0] special_res;

    always_comb begin
        in_signed   = ~op[0];
        in_rem      = op[1];
        div_zero    = (rs2_val == 32'd0);
        sgn_ovf     = in_signed && (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
        special     = div_zero || sgn_ovf;
        abs1        = (in_signed && rs1_val[31]) ? (~rs1_val + 32'd1) : rs1_val;
        abs2        = (in_signed && rs2_val[31]) ? (~rs2_val + 32'd1) : rs2_val;
        special_res = 32'd0;
        if (div_zero) begin
            special_res = in_rem ? rs1_val : 32'hFFFF_FFFF;
        end else begin
            special_res = in_rem ? 32'd0 : 32'h8000_0000;
        end
    end

    // One restoring step; the partial remainder stays below the divisor,
    // so the shifted value needs 33 bits but the difference fits in 32.
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] final_q;
    logic [31:0] final_r;
    logic [31:0] calc_res;

    always_comb begin
        shifted  = {rem_q, quo_q[31]};
        ge       = (shifted >= {1'b0, dvs_q});
        rem_next = ge ? (shifted[31:0] - dvs_q) : shifted[31:0];
        quo_next = {quo_q[30:0], ge};
        final_q  = q_neg_q ? (~quo_next + 32'd1) : quo_next;
        final_r  = r_neg_q ? (~rem_next + 32'd1) : rem_next;
        calc_res = rem_op_q ? final_r : final_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 6'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 6'd0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            dvs_q     <= 32'd0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            rem_op_q  <= 1'b0;
            rd_q      <= 5'd0;
            wr_ena_q  <= 1'b0;
            wr_reg_q  <= 5'd0;
            wr_data_q <= 32'd0;
        end else begin
            wr_ena_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_q    <= 6'd0;
                        quo_q    <= abs1;
                        rem_q    <= 32'd0;
                        dvs_q    <= abs2;
                        q_neg_q  <= in_signed && (rs1_val[31] ^ rs2_val[31]);
                        r_neg_q  <= in_signed && rs1_val[31];
                        rem_op_q <= in_rem;
                        rd_q     <= rd;
                        if (special) begin
                            wr_data_q <= special_res;
                            wr_reg_q  <= rd;
                            wr_ena_q  <= (rd != 5'd0);
                        end
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        quo_q <= quo_next;
                        rem_q <= rem_next;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            wr_data_q <= calc_res;
                            wr_reg_q  <= rd_q;
                            wr_ena_q  <= (rd_q != 5'd0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs; a flush in DONE suppresses the write in that same cycle
    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        wr_ena  = wr_ena_q && !flush;
        wr_reg  = wr_reg_q;
        wr_data = wr_data_q;
    end

endmodule
